// File: rtl/ldpc_idx_pkg.sv
// Shared constants and state encoding for the check-node index unpack stream.
package ldpc_idx_pkg;

  localparam int IDX_W   = 14;
  localparam int NUM_IDX = 35;
  localparam int POS_W   = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_SCAN = SCAN,
    ST_DONE = DONE
  } state_e;

endpackage

// File: rtl/idx_first_set.sv
// Priority encoder over the pending-slot mask. DESCEND=0 picks the lowest
// set bit, DESCEND=1 the highest. Also reports whether any bit is set and
// whether exactly one bit is set.
module idx_first_set #(
  parameter int N       = 35,
  parameter int PW      = 6,
  parameter bit DESCEND = 1'b0
) (
  input  logic [N-1:0]  vec,
  output logic [PW-1:0] pos,
  output logic          found,
  output logic          single
);

  // Later loop iterations override earlier ones, so the scan order decides priority.
  always_comb begin
    pos = '0;
    if (DESCEND) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) pos = PW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) pos = PW'(i);
      end
    end
  end

  // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
  always_comb begin
    found  = |vec;
    single = found && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/index_unpack_stream.sv
// Unpacks a 35-slot x 14-bit check-node index vector and streams its
// non-zero slots one per handshake, with slot position and a last flag.
// Build option INDEX_STREAM_DESCEND_EN reverses emission order (highest
// slot first); handshake, last, done and count behaviour are unchanged.
//
// Handshake: an index transfers on a rising edge where idx_valid and
// idx_ready are both high; idx_valid never depends on idx_ready, and
// idx_data/idx_pos/idx_last hold while idx_valid=1 and idx_ready=0.
module index_unpack_stream
  import ldpc_idx_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [IDX_W*NUM_IDX-1:0] index_vec_in,
  output logic                     busy,
  output logic                     idx_valid,
  input  logic                     idx_ready,
  output logic [IDX_W-1:0]         idx_data,
  output logic [POS_W-1:0]         idx_pos,
  output logic                     idx_last,
  output logic                     done,
  output logic [POS_W-1:0]         emit_cnt
);

`ifdef INDEX_STREAM_DESCEND_EN
  localparam bit DESCEND = 1'b1;
`else
  localparam bit DESCEND = 1'b0;
`endif

  state_e                     state_q, state_d;
  logic [IDX_W*NUM_IDX-1:0]   shadow_q;
  logic [NUM_IDX-1:0]         mask_q, mask_load, mask_next, sel_oh;
  logic [POS_W-1:0]           sel_pos, emit_cnt_q;
  logic [IDX_W-1:0]           sel_data;
  logic                       sel_found, sel_single;
  logic                       capture, fire;

  idx_first_set #(
    .N       (NUM_IDX),
    .PW      (POS_W),
    .DESCEND (DESCEND)
  ) u_first_set (
    .vec    (mask_q),
    .pos    (sel_pos),
    .found  (sel_found),
    .single (sel_single)
  );

  // A slot is pending when any of its bits is set; zero slots are never emitted.
  always_comb begin
    mask_load = '0;
    for (int k = 0; k < NUM_IDX; k++) begin
      mask_load[k] = |index_vec_in[k*IDX_W +: IDX_W];
    end
  end

  // Decode the selected position to a one-hot clear mask and pick its slot value.
  always_comb begin
    sel_oh   = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_IDX; k++) begin
      if (sel_pos == POS_W'(k)) begin
        sel_oh[k] = 1'b1;
        sel_data  = shadow_q[k*IDX_W +: IDX_W];
      end
    end
  end

  // Next-state and handshake control; the SCAN exit looks at the post-accept mask.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    idx_valid = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    fire      = 1'b0;
    mask_next = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          capture = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy      = 1'b1;
        idx_valid = sel_found;
        fire      = sel_found & idx_ready;
        if (fire) mask_next = mask_q & ~sel_oh;
        if (mask_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Presented index fields are forced to zero whenever nothing is offered.
  always_comb begin
    idx_data = idx_valid ? sel_data : '0;
    idx_pos  = idx_valid ? sel_pos  : '0;
    idx_last = idx_valid & sel_single;
    emit_cnt = emit_cnt_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Shadow vector, pending mask and accepted-index counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      mask_q     <= '0;
      emit_cnt_q <= '0;
    end else if (capture) begin
      shadow_q   <= index_vec_in;
      mask_q     <= mask_load;
      emit_cnt_q <= '0;
    end else begin
      mask_q <= mask_next;
      if (fire) emit_cnt_q <= emit_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_index_unpack_stream.sv
// Testbench for index_unpack_stream: behavioural queue model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_index_unpack_stream;
  import ldpc_idx_pkg::*;

  localparam int VW = IDX_W * NUM_IDX;
  localparam int EW = POS_W + IDX_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic             idx_ready = 1'b0;
  logic [VW-1:0]    index_vec_in = '0;
  logic             busy, idx_valid, idx_last, done;
  logic [IDX_W-1:0] idx_data;
  logic [POS_W-1:0] idx_pos, emit_cnt;

  always #5 clk = ~clk;

  index_unpack_stream dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .index_vec_in (index_vec_in),
    .busy         (busy),
    .idx_valid    (idx_valid),
    .idx_ready    (idx_ready),
    .idx_data     (idx_data),
    .idx_pos      (idx_pos),
    .idx_last     (idx_last),
    .done         (done),
    .emit_cnt     (emit_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int rdy_mode = 0;   // 0: always 1, 1: toggle, 2: random, 3: always 0

  logic [EW-1:0] exp_q[$];   // remaining entries the model expects, head = presented
  logic [EW-1:0] log_q[$];   // entries the DUT actually transferred
  bit            m_stream = 1'b0;
  bit            m_done   = 1'b0;
  int            m_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int p, input int d);
    return {POS_W'(p), IDX_W'(d)};
  endfunction

  // Expected emission order of the non-zero slots of v.
  function automatic void model_load(input logic [VW-1:0] v);
    int k;
    exp_q.delete();
    for (int j = 0; j < NUM_IDX; j++) begin
`ifdef INDEX_STREAM_DESCEND_EN
      k = NUM_IDX - 1 - j;
`else
      k = j;
`endif
      if (v[k*IDX_W +: IDX_W] != '0) exp_q.push_back({POS_W'(k), v[k*IDX_W +: IDX_W]});
    end
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_stream = 1'b0;
      m_done   = 1'b0;
      m_cnt    = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_stream) begin
      if (exp_q.size() > 0 && idx_ready) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (exp_q.size() == 0) begin
        m_stream = 1'b0;
        m_done   = 1'b1;
      end
    end else if (load) begin
      model_load(index_vec_in);
      m_cnt    = 0;
      m_stream = 1'b1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    bit e_valid;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_valid", idx_valid, 0);
      chk("rst_data", idx_data, 0);
      chk("rst_pos", idx_pos, 0);
      chk("rst_last", idx_last, 0);
      chk("rst_done", done, 0);
      chk("rst_emit_cnt", emit_cnt, 0);
    end else begin
      e_valid = m_stream && (exp_q.size() > 0);
      chk("busy", busy, m_stream || m_done);
      chk("idx_valid", idx_valid, e_valid);
      chk("done", done, m_done);
      chk("emit_cnt", emit_cnt, m_cnt);
      if (e_valid) begin
        chk("idx_data", idx_data, exp_q[0][IDX_W-1:0]);
        chk("idx_pos", idx_pos, exp_q[0][EW-1:IDX_W]);
        chk("idx_last", idx_last, exp_q.size() == 1);
      end
      if (idx_valid && idx_ready) log_q.push_back({idx_pos, idx_data});
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       idx_ready = 1'b1;
      1:       idx_ready = ~idx_ready;
      2:       idx_ready = 1'($urandom_range(0, 1));
      default: idx_ready = 1'b0;
    endcase
  end

  task automatic do_load(input logic [VW-1:0] v);
    @(posedge clk); #1;
    load = 1'b1;
    index_vec_in = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (done !== 1'b1) chk(name, 0, 1);
  endtask

  task automatic wait_first_xfer(input string name);
    int c;
    c = 0;
    while (log_q.size() == 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (log_q.size() == 0) chk(name, 0, 1);
  endtask

  function automatic logic [VW-1:0] t1_vec();
    logic [VW-1:0] v;
    v = '0;
    v[0*IDX_W  +: IDX_W] = 14'h0011;
    v[5*IDX_W  +: IDX_W] = 14'h1ABC;
    v[34*IDX_W +: IDX_W] = 14'h3FFF;
    return v;
  endfunction

  function automatic logic [EW-1:0] t1_exp(input int i);
    logic [EW-1:0] a [3];
    a[0] = ent(0, 'h0011);
    a[1] = ent(5, 'h1ABC);
    a[2] = ent(34, 'h3FFF);
`ifdef INDEX_STREAM_DESCEND_EN
    return a[2 - i];
`else
    return a[i];
`endif
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] v;
    int lat, nz;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Sparse vector, ready held high.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    log_q.delete();
    do_load(t1_vec());
    wait_done("t1_done_timeout");
    @(negedge clk);
    chk("t1_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk("t1_entry", log_q[i], t1_exp(i));
    chk("t1_emit_cnt", emit_cnt, 3);

    // All-zero vector: no valid, done two cycles after the load cycle.
    repeat (2) @(posedge clk);
    log_q.delete();
    @(posedge clk); #1;
    load = 1'b1;
    index_vec_in = '0;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done && lat < 0) lat = i;
      if (i == 0) begin
        @(posedge clk); #1;
        load = 1'b0;
      end
    end
    chk("t2_done_latency", lat, 2);
    chk("t2_count", log_q.size(), 0);
    chk("t2_emit_cnt", emit_cnt, 0);

    // Full vector k+1, ready toggling.
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    log_q.delete();
    v = '0;
    for (int k = 0; k < NUM_IDX; k++) v[k*IDX_W +: IDX_W] = IDX_W'(k + 1);
    do_load(v);
    wait_done("t3_done_timeout");
    @(negedge clk);
    chk("t3_count", log_q.size(), NUM_IDX);
    for (int i = 0; i < NUM_IDX && i < log_q.size(); i++) begin
`ifdef INDEX_STREAM_DESCEND_EN
      chk("t3_entry", log_q[i], ent(NUM_IDX - 1 - i, NUM_IDX - i));
`else
      chk("t3_entry", log_q[i], ent(i, i + 1));
`endif
    end
    chk("t3_emit_cnt", emit_cnt, NUM_IDX);

    // Load reasserted mid-stream is ignored.
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    log_q.delete();
    do_load(t1_vec());
    wait_first_xfer("t4_first_timeout");
    v = '0;
    for (int k = 0; k < NUM_IDX; k++) v[k*IDX_W +: IDX_W] = 14'h0AAA;
    do_load(v);
    wait_done("t4_done_timeout");
    @(negedge clk);
    chk("t4_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk("t4_entry", log_q[i], t1_exp(i));
    chk("t4_emit_cnt", emit_cnt, 3);

    // Reset after the first acceptance aborts the stream.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    log_q.delete();
    do_load(t1_vec());
    wait_first_xfer("t5_first_timeout");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", idx_valid, 0);
    chk("t5_rst_data", idx_data, 0);
    chk("t5_rst_pos", idx_pos, 0);
    chk("t5_rst_last", idx_last, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_emit_cnt", emit_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    log_q.delete();
    do_load(t1_vec());
    wait_done("t5_done_timeout");
    @(negedge clk);
    chk("t5_count", log_q.size(), 3);
    if (log_q.size() > 0) chk("t5_first_entry", log_q[0], t1_exp(0));
    chk("t5_emit_cnt", emit_cnt, 3);

    // Random vectors with random backpressure.
    rdy_mode = 2;
    for (int t = 0; t < 25; t++) begin
      repeat (2) @(posedge clk);
      v = '0;
      nz = 0;
      for (int k = 0; k < NUM_IDX; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          v[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(1, (1 << IDX_W) - 1));
          nz++;
        end
      end
      if (t == 0) begin
        v = '0;
        v[17*IDX_W + IDX_W - 1] = 1'b1;
        nz = 1;
      end
      do_load(v);
      wait_done("t6_done_timeout");
      @(negedge clk);
      chk("t6_emit_cnt", emit_cnt, nz);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/index_unpack_stream.md
Name: index_unpack_stream

Overview:
- Consumer side of the packed check-node index vector (35 slots x 14 bit, zero = empty slot) that feeds the q-unit.
- Loads one packed vector, then streams its non-zero entries out one per handshake, with slot position and a last flag.
- Zero slots are skipped with no bubble cycles.
- Sits between the index compaction stage and the serial q-unit update datapath.

Parameters:
- IDX_W, 14, width of one index entry.
- NUM_IDX, 35, number of slots in the packed vector (32+3).
- POS_W, 6, width of the slot position output; must satisfy 2^POS_W >= NUM_IDX.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  single-cycle request to capture index_vec_in; accepted only in IDLE.
- index_vec_in  in  IDX_W*NUM_IDX  packed vector; slot k occupies bits [k*IDX_W +: IDX_W].
- busy  out  1  high in SCAN and DONE.
- idx_valid  out  1  a current index is presented.
- idx_ready  in  1  downstream accepts the current index.
- idx_data  out  IDX_W  current index value.
- idx_pos  out  POS_W  slot number of the current index.
- idx_last  out  1  current index is the final non-zero entry.
- done  out  1  one-cycle pulse when the vector is exhausted.
- emit_cnt  out  POS_W  number of indices accepted since the last load.

Behaviour:
- Reset (async, rst=1): state=IDLE, shadow vector=0, pending mask=0, emit_cnt=0.
  - All outputs 0 during reset: busy, idx_valid, idx_data, idx_pos, idx_last, done.
  - Reset asserted mid-SCAN aborts the stream immediately. No done pulse is produced.
- States:
  - IDLE: busy=0.
    - load=1 registers index_vec_in into the shadow register.
    - Pending mask bit k is set to OR-reduce of slot k.
    - emit_cnt clears to 0.
    - Next state is SCAN. load has one cycle of latency: idx_valid is first seen the cycle after load.
  - SCAN:
    - idx_valid = (mask != 0).
    - The selected slot is the lowest set bit of the mask. idx_data = shadow[sel], idx_pos = sel.
    - idx_last = exactly one mask bit set.
    - On idx_valid & idx_ready: clear mask[sel] and increment emit_cnt. The next non-zero slot is presented the following cycle, so throughput is 1 index/cycle.
    - If the mask is zero, go to DONE. This includes an all-zero load, which gives 0 indices and one cycle in SCAN.
    - The transition is evaluated on the post-update mask: accepting the last entry moves to DONE on the same edge.
  - DONE: done=1 for exactly one cycle, busy=1, idx_valid=0; next state is IDLE.
- Outputs are combinational from registered shadow/mask state. idx_data, idx_pos and idx_last hold stable while idx_valid=1 and idx_ready=0.
- load is ignored in SCAN and DONE: no re-capture and no error. load in the same cycle as the done pulse is also ignored.
- idx_ready while idx_valid=0 has no effect.
- emit_cnt holds its final value until the next accepted load. Maximum is 35, which fits in POS_W.
- Non-zero test is per-slot OR across all IDX_W bits. An index value of 0 can never be emitted.

Optional Feature:
- Macro INDEX_STREAM_DESCEND_EN.
- Defined: the selected slot is the highest set mask bit, so emission runs from slot NUM_IDX-1 down to slot 0.
- Not defined: emission is ascending, lowest slot first.
- All handshake, last, done and count behaviour is identical in both builds.

Decomposition:
- Package ldpc_idx_pkg holds:
  - IDX_W, NUM_IDX, POS_W constants.
  - State encoding localparams: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
- One sub-module, idx_first_set:
  - Parameterised NUM_IDX-wide priority encoder.
  - Outputs the selected position, found flag and single-bit flag.
  - Direction is selected by a parameter driven from the macro.

Test Plan:
- Nonzero slots 0,5,34 = 0x0011, 0x1ABC, 0x3FFF; idx_ready held 1 -> on three consecutive cycles (pos,data) = (0,0x0011), (5,0x1ABC), (34,0x3FFF); idx_last only on the third; done one cycle later; emit_cnt=3.
- All-zero vector loaded -> idx_valid never asserts; done pulses exactly 2 cycles after load; emit_cnt=0.
- All 35 slots = k+1; idx_ready toggled 1,0,1,0 -> 35 transfers in ascending order; data and pos stable through stalls; done after the 35th acceptance; emit_cnt=35.
- load reasserted with a different vector in the middle of the first test's stream -> ignored; the stream still produces the original three entries.
- rst pulsed after the first acceptance of the first test's stream -> all outputs 0 asynchronously; no done; a fresh load afterwards streams normally from slot 0.
- INDEX_STREAM_DESCEND_EN build, the first test's vector -> order (34,0x3FFF), (5,0x1ABC), (0,0x0011); idx_last on pos 0.
